// File: rtl/config_loader_pkg.sv
// rtl/config_loader_pkg.sv - shared state encoding and sizing helpers for config_loader
package config_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  function automatic int num_words(input int cfg_w, input int word_w);
    return (cfg_w + word_w - 1) / word_w;
  endfunction

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/config_loader.sv
// rtl/config_loader.sv - bitstream loader: assembles words into a shadow register,
// verifies a trailing XOR checksum and commits atomically to the fabric config bus.
module config_loader
  import config_loader_pkg::*;
#(
  parameter int CONFIG_WIDTH = 17,
  parameter int WORD_WIDTH   = 8
) (
  input  logic                    clock,
  input  logic                    nreset,
  input  logic                    start,
  input  logic [WORD_WIDTH-1:0]   data_in,
  input  logic                    data_valid,
  output logic                    data_ready,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    config_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int NUM_WORDS = num_words(CONFIG_WIDTH, WORD_WIDTH);
  localparam int SHADOW_W  = NUM_WORDS * WORD_WIDTH;
  localparam int CNT_W     = clog2(NUM_WORDS + 1);

  state_t                  r_state;
  logic [CNT_W-1:0]        r_count;
  logic [WORD_WIDTH-1:0]   r_acc;
  logic [CONFIG_WIDTH-1:0] r_shadow;
  logic [CONFIG_WIDTH-1:0] r_config;
  logic                    r_config_valid;
  logic                    r_ready;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_error;

  // Word placed at its slot; the cast drops pad bits above CONFIG_WIDTH.
  logic [CONFIG_WIDTH-1:0] w_ins;
  assign w_ins = CONFIG_WIDTH'(SHADOW_W'(data_in) << (r_count * WORD_WIDTH));

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_state        <= ST_IDLE;
      r_count        <= '0;
      r_acc          <= '0;
      r_shadow       <= '0;
      r_config       <= '0;
      r_config_valid <= 1'b0;
      r_ready        <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      if (start) begin
        // Start from any state (re)begins a load; a word in this cycle is ignored.
        r_state  <= ST_LOAD;
        r_count  <= '0;
        r_acc    <= '0;
        r_shadow <= '0;
        r_ready  <= 1'b1;
        r_busy   <= 1'b1;
      end else begin
        case (r_state)
          ST_LOAD: begin
            if (data_valid) begin
              r_shadow <= r_shadow | w_ins;
              r_acc    <= r_acc ^ data_in;
              r_count  <= r_count + CNT_W'(1);
              if (r_count == CNT_W'(NUM_WORDS - 1)) begin
                r_state <= ST_CHECK;
              end
            end
          end
          ST_CHECK: begin
            if (data_valid) begin
              if (data_in == r_acc) begin
                r_config       <= r_shadow;
                r_config_valid <= 1'b1;
                r_done         <= 1'b1;
              end else begin
                r_error <= 1'b1;
              end
              r_state <= ST_IDLE;
              r_ready <= 1'b0;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_ready   = r_ready;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign config_out   = r_config;
  assign config_valid = r_config_valid;

endmodule

// File: tb/tb_config_loader.sv
// tb/tb_config_loader.sv - directed self-checking bench for config_loader
`timescale 1ns/1ps
module tb_config_loader;

  logic        clock;
  logic        nreset;
  logic        start;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        data_ready;
  logic [16:0] config_out;
  logic        config_valid;
  logic        busy;
  logic        done;
  logic        error;

  int n_checks;
  int n_fail;

  config_loader #(.CONFIG_WIDTH(17), .WORD_WIDTH(8)) dut (
    .clock        (clock),
    .nreset       (nreset),
    .start        (start),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .config_out   (config_out),
    .config_valid (config_valid),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] w);
    data_in    = w;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    nreset     = 1'b0;
    start      = 1'b0;
    data_in    = 8'h00;
    data_valid = 1'b0;
    #2;
    chk("rst_config_out", 32'(config_out), 32'h0);
    chk("rst_config_valid", 32'(config_valid), 32'h0);
    chk("rst_ready", 32'(data_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_error", 32'(error), 32'h0);
    #10;
    nreset = 1'b1;
    step();

    // 1: basic load
    pulse_start();
    chk("t1_ready", 32'(data_ready), 32'h1);
    chk("t1_busy", 32'(busy), 32'h1);
    send(8'hAB);
    send(8'hCD);
    send(8'h01);
    chk("t1_check_cfg_held", 32'(config_out), 32'h0);
    send(8'h67);
    chk("t1_cfg", 32'(config_out), 32'h1CDAB);
    chk("t1_valid", 32'(config_valid), 32'h1);
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_error", 32'(error), 32'h0);
    chk("t1_busy_low", 32'(busy), 32'h0);
    chk("t1_ready_low", 32'(data_ready), 32'h0);
    step();
    chk("t1_done_once", 32'(done), 32'h0);

    // 2: bad checksum keeps the previous configuration
    pulse_start();
    send(8'h11);
    send(8'h22);
    send(8'h00);
    send(8'h00);
    chk("t2_error", 32'(error), 32'h1);
    chk("t2_done", 32'(done), 32'h0);
    chk("t2_cfg", 32'(config_out), 32'h1CDAB);
    chk("t2_valid", 32'(config_valid), 32'h1);
    step();
    chk("t2_error_once", 32'(error), 32'h0);

    // 3: pad bits and backpressure
    pulse_start();
    send(8'hFF);
    gap(3);
    chk("t3_busy_stall", 32'(busy), 32'h1);
    send(8'h00);
    gap(3);
    send(8'hFF);
    gap(3);
    chk("t3_cfg_held", 32'(config_out), 32'h1CDAB);
    send(8'h00);
    chk("t3_cfg", 32'(config_out), 32'h100FF);
    chk("t3_done", 32'(done), 32'h1);
    step();

    // 4: restart mid-load; the word presented with start is dropped
    pulse_start();
    send(8'h12);
    send(8'h34);
    data_in    = 8'h56;
    data_valid = 1'b1;
    start      = 1'b1;
    step();
    start      = 1'b0;
    data_valid = 1'b0;
    chk("t4_busy_restart", 32'(busy), 32'h1);
    chk("t4_cfg_held", 32'(config_out), 32'h100FF);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    send(8'h00);
    chk("t4_cfg", 32'(config_out), 32'h10201);
    chk("t4_done", 32'(done), 32'h1);
    chk("t4_error", 32'(error), 32'h0);
    step();

    // 5: asynchronous reset mid-load
    pulse_start();
    send(8'hAA);
    #2;
    nreset = 1'b0;
    #1;
    chk("t5_cfg", 32'(config_out), 32'h0);
    chk("t5_valid", 32'(config_valid), 32'h0);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_ready", 32'(data_ready), 32'h0);
    step();
    nreset = 1'b1;
    step();
    step();
    chk("t5_idle_ready", 32'(data_ready), 32'h0);
    chk("t5_idle_busy", 32'(busy), 32'h0);

    // 6: words without start are ignored
    pulse_start();
    send(8'hAB);
    send(8'hCD);
    send(8'h01);
    send(8'h67);
    chk("t6_cfg_loaded", 32'(config_out), 32'h1CDAB);
    data_in    = 8'h5A;
    data_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t6_idle_ready", 32'(data_ready), 32'h0);
      chk("t6_idle_cfg", 32'(config_out), 32'h1CDAB);
    end
    data_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
